// File: rtl/control_unit_pkg.sv
// Shared encodings for the control unit: opcodes, FSM states, ALU operations
// and the bundle of registered control outputs.
package control_unit_pkg;

    localparam int INSTR_W = 16;
    localparam int DADDR_W = 8;
    localparam int RADDR_W = 4;

    // Opcodes are plain constants so that unassigned codes 6..15 stay legal values.
    localparam logic [3:0] OP_NOOP  = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0001;
    localparam logic [3:0] OP_LOAD  = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_HALT  = 4'b0101;

    typedef enum logic [3:0] {
        ST_INIT   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_NOOP   = 4'd3,
        ST_LOAD_A = 4'd4,
        ST_LOAD_B = 4'd5,
        ST_STORE  = 4'd6,
        ST_ADD    = 4'd7,
        ST_SUB    = 4'd8,
        ST_HALT   = 4'd9
    } state_e;

    typedef enum logic [2:0] {
        ALU_PASS_A = 3'b000,
        ALU_ADD    = 3'b001,
        ALU_SUB    = 3'b010
    } alu_op_e;

    typedef struct packed {
        logic               pc_clear;
        logic               pc_up;
        logic [DADDR_W-1:0] d_addr;
        logic               d_wr;
        logic               rf_sel;
        logic [RADDR_W-1:0] rf_w_addr;
        logic [RADDR_W-1:0] rf_ra_addr;
        logic [RADDR_W-1:0] rf_rb_addr;
        logic               rf_w_wr;
        logic [2:0]         alu_op;
        logic               halted;
    } ctrl_t;

    function automatic logic [3:0] ir_opcode(input logic [INSTR_W-1:0] ir);
        return ir[15:12];
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Bus between the control unit and the datapath (PC, IR source, memories, RF, ALU).
interface control_unit_if;
    import control_unit_pkg::*;

    logic [INSTR_W-1:0] instr;
    logic               pc_clear;
    logic               pc_up;
    logic [DADDR_W-1:0] d_addr;
    logic               d_wr;
    logic               rf_sel;
    logic [RADDR_W-1:0] rf_w_addr;
    logic [RADDR_W-1:0] rf_ra_addr;
    logic [RADDR_W-1:0] rf_rb_addr;
    logic               rf_w_wr;
    logic [2:0]         alu_op;

    modport master (
        input  instr,
        output pc_clear, pc_up, d_addr, d_wr, rf_sel,
        output rf_w_addr, rf_ra_addr, rf_rb_addr, rf_w_wr, alu_op
    );

    modport slave (
        output instr,
        input  pc_clear, pc_up, d_addr, d_wr, rf_sel,
        input  rf_w_addr, rf_ra_addr, rf_rb_addr, rf_w_wr, alu_op
    );

endinterface

// File: rtl/control_unit_instruction_register.sv
// Instruction register: synchronous load, synchronous active-low clear.
module instruction_register #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         clear_n,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] ir_q;
    logic [W-1:0] ir_d;

    always_comb begin
        ir_d = ir_q;
        if (load) begin
            ir_d = d;
        end
    end

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            ir_q <= '0;
        end else begin
            ir_q <= ir_d;
        end
    end

    assign q = ir_q;

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control FSM: fetch, decode, execute. All outputs are registered and
// computed from the state being entered, so they line up with the state output.
module control_unit
    import control_unit_pkg::*;
(
    input  logic           clock,
    input  logic           clear_n,
    control_unit_if.master bus,
    output logic [3:0]     state,
    output logic           halted
);

    state_e             state_q;
    state_e             state_d;
    ctrl_t              ctrl_q;
    ctrl_t              ctrl_d;
    logic [INSTR_W-1:0] ir;

    logic [3:0]         opcode;
    logic [RADDR_W-1:0] rx;
    logic [RADDR_W-1:0] rb;
    logic [RADDR_W-1:0] rd;
    logic [DADDR_W-1:0] maddr;

    instruction_register #(.W(INSTR_W)) u_ir (
        .clock   (clock),
        .clear_n (clear_n),
        .load    (state_q == ST_FETCH),
        .d       (bus.instr),
        .q       (ir)
    );

    assign opcode = ir_opcode(ir);
    assign rx     = ir[11:8];
    assign rb     = ir[7:4];
    assign rd     = ir[3:0];
    assign maddr  = ir[7:0];

    // INIT is held through reset with pc_clear low; the first cycle after release
    // raises pc_clear, and pc_clear already high marks INIT as done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:   state_d = ctrl_q.pc_clear ? ST_FETCH : ST_INIT;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                case (opcode)
                    OP_STORE: state_d = ST_STORE;
                    OP_LOAD:  state_d = ST_LOAD_A;
                    OP_ADD:   state_d = ST_ADD;
                    OP_SUB:   state_d = ST_SUB;
                    OP_HALT:  state_d = ST_HALT;
                    default:  state_d = ST_NOOP;
                endcase
            end
            ST_LOAD_A: state_d = ST_LOAD_B;
            ST_LOAD_B: state_d = ST_FETCH;
            ST_NOOP:   state_d = ST_FETCH;
            ST_STORE:  state_d = ST_FETCH;
            ST_ADD:    state_d = ST_FETCH;
            ST_SUB:    state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_INIT;
        endcase
    end

    // IR is stable whenever an execute state is entered (loaded at the end of FETCH).
    always_comb begin
        ctrl_d = '0;
        case (state_d)
            ST_INIT:   ctrl_d.pc_clear = 1'b1;
            ST_FETCH:  ctrl_d.pc_up = 1'b1;
            ST_LOAD_A: begin
                ctrl_d.d_addr    = maddr;
                ctrl_d.rf_sel    = 1'b1;
                ctrl_d.rf_w_addr = rx;
            end
            ST_LOAD_B: begin
                ctrl_d.d_addr    = maddr;
                ctrl_d.rf_sel    = 1'b1;
                ctrl_d.rf_w_addr = rx;
                ctrl_d.rf_w_wr   = 1'b1;
            end
            ST_STORE: begin
                ctrl_d.d_addr     = maddr;
                ctrl_d.rf_ra_addr = rx;
                ctrl_d.d_wr       = 1'b1;
            end
            ST_ADD, ST_SUB: begin
                ctrl_d.rf_ra_addr = rx;
                ctrl_d.rf_rb_addr = rb;
                ctrl_d.rf_w_addr  = rd;
                ctrl_d.rf_w_wr    = 1'b1;
                ctrl_d.alu_op     = (state_d == ST_ADD) ? ALU_ADD : ALU_SUB;
            end
            ST_HALT:   ctrl_d.halted = 1'b1;
            default:   ctrl_d = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            state_q <= ST_INIT;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign bus.pc_clear   = ctrl_q.pc_clear;
    assign bus.pc_up      = ctrl_q.pc_up;
    assign bus.d_addr     = ctrl_q.d_addr;
    assign bus.d_wr       = ctrl_q.d_wr;
    assign bus.rf_sel     = ctrl_q.rf_sel;
    assign bus.rf_w_addr  = ctrl_q.rf_w_addr;
    assign bus.rf_ra_addr = ctrl_q.rf_ra_addr;
    assign bus.rf_rb_addr = ctrl_q.rf_rb_addr;
    assign bus.rf_w_wr    = ctrl_q.rf_w_wr;
    assign bus.alu_op     = ctrl_q.alu_op;
    assign state          = state_q;
    assign halted         = ctrl_q.halted;

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have the port clock, input, 1 bit: the system clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port clear_n, input, 1 bit: reset, synchronous and active-low.
REQ-003 The block SHALL have the port instr, input, 16 bits: instruction word from instruction memory at the current program counter address.
REQ-004 The block SHALL have the port pc_clear, output, 1 bit: synchronous clear to program_counter.
REQ-005 The block SHALL have the port pc_up, output, 1 bit: increment request to program_counter (+4 per pulse).
REQ-006 The block SHALL have the ports d_addr (output, 8 bits) and d_wr (output, 1 bit): data-memory address and write enable.
REQ-007 The block SHALL have the port rf_sel, output, 1 bit: register-file write source; 1 = data memory, 0 = ALU.
REQ-008 The block SHALL have the ports rf_w_addr, rf_ra_addr and rf_rb_addr, outputs, 4 bits each, and rf_w_wr, output, 1 bit: register-file write address, read addresses and write enable.
REQ-009 The block SHALL have the port alu_op, output, 3 bits: 000 = pass A, 001 = A+B, 010 = A-B.
REQ-010 The block SHALL have the ports state, output, 4 bits (current state encoding, debug), and halted, output, 1 bit.

Function
REQ-011 Instruction fields SHALL be: opcode ir[15:12]; Rx ir[11:8]; memory address ir[7:0]; Rb ir[7:4]; Rd ir[3:0].
REQ-012 Opcodes SHALL be: NOOP 0000; STORE 0001 (D[ir[7:0]] <- R[Rx]); LOAD 0010 (R[Rx] <- D[ir[7:0]]); ADD 0011 (R[Rd] <- R[Rx]+R[Rb]); SUB 0100 (R[Rd] <- R[Rx]-R[Rb]); HALT 0101. Opcodes 0110-1111 SHALL execute as NOOP.
REQ-013 The states SHALL be INIT=0, FETCH=1, DECODE=2, NOOP=3, LOAD_A=4, LOAD_B=5, STORE=6, ADD=7, SUB=8, HALT=9.
REQ-014 INIT SHALL assert pc_clear for exactly one cycle and then go to FETCH.
REQ-015 FETCH SHALL capture instr into the internal IR, assert pc_up for exactly one cycle and then go to DECODE.
REQ-016 DECODE SHALL assert no write strobe and SHALL branch on the IR opcode to NOOP, LOAD_A, STORE, ADD, SUB or HALT.
REQ-017 NOOP, STORE, ADD, SUB and LOAD_B SHALL each last one cycle and then go to FETCH; LOAD_A SHALL last one cycle and then go to LOAD_B, covering the one-cycle data-memory read latency.
REQ-018 LOAD_A and LOAD_B SHALL drive d_addr=ir[7:0], rf_sel=1 and rf_w_addr=Rx; rf_w_wr SHALL be asserted in LOAD_B only.
REQ-019 STORE SHALL drive d_addr=ir[7:0], rf_ra_addr=Rx and d_wr=1.
REQ-020 ADD and SUB SHALL drive rf_ra_addr=Rx, rf_rb_addr=Rb, rf_w_addr=Rd, rf_sel=0, rf_w_wr=1, and alu_op=001 for ADD or 010 for SUB.
REQ-021 HALT SHALL be absorbing: pc_up, d_wr and rf_w_wr held 0, halted=1; only clear_n low SHALL leave HALT.
REQ-022 pc_up SHALL pulse exactly once per executed instruction, so address advances by exactly 4 per instruction, with 16-bit wrap handled in program_counter.
REQ-023 In any state not named in REQ-018 to REQ-020, d_wr, rf_w_wr, pc_clear and pc_up SHALL be 0 unless that state's own requirement asserts them, and address outputs SHALL be 0.
REQ-024 Cycle counts SHALL be: NOOP, STORE, ADD and SUB take 3 cycles; LOAD takes 4 cycles.

Reset
REQ-025 When clear_n=0 at a rising edge, the state SHALL become INIT, IR SHALL become 0 and halted SHALL become 0, from any state, including mid-LOAD with no write-back issued.
REQ-026 While in reset, all strobes SHALL be 0.

Structure
REQ-027 Opcode constants, state encodings and alu_op codes SHALL live in a shared package/include used by the ALU and the testbench.
REQ-028 The IR SHALL be a sub-module, instruction_register (16 bits, synchronous load, clear_n).

Verification
REQ-029 clear_n low for 2 cycles, then high -> pc_clear=1 for one cycle, followed by FETCH with pc_up=1.
REQ-030 instr=16'h2A05 (LOAD R10 <- D[5]) -> d_addr=5 in LOAD_A and LOAD_B; rf_w_wr=1 with rf_w_addr=10, rf_sel=1 in LOAD_B only.
REQ-031 instr=16'h3123 (ADD R3=R1+R2) -> in the single ADD cycle, rf_ra_addr=1, rf_rb_addr=2, rf_w_addr=3, alu_op=001, rf_w_wr=1.
REQ-032 instr=16'h1307 (STORE D[7] <- R3) -> d_wr=1 and d_addr=7 for one cycle; rf_w_wr stays 0.
REQ-033 instr=16'h5000 (HALT), then 20 cycles -> halted=1 and pc_up=0 throughout; clear_n low returns the state to INIT.
REQ-034 clear_n low during LOAD_A -> no rf_w_wr pulse; the next state is INIT.
